// File: rtl/btn_ctrl_bank_if.sv
// Button bank signal bundle: raw pins and clear in, debounced levels, pulses,
// toggles and selector out. The master drives the pins, the slave is the controller.
interface btn_ctrl_bank_if #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH-1:0]   btn;
  logic             clr_toggle;
  logic [NCH-1:0]   level;
  logic [NCH-1:0]   press;
  // Falling-edge pulse; "release" is a reserved word in SystemVerilog.
  logic [NCH-1:0]   rel;
  logic [NCH-1:0]   toggle;
  logic [NCH-1:0]   long_press;
  logic [SEL_W-1:0] sel;

  modport master (
    output btn, clr_toggle,
    input  level, press, rel, toggle, long_press, sel
  );

  modport slave (
    input  btn, clr_toggle,
    output level, press, rel, toggle, long_press, sel
  );
endinterface

// File: rtl/btn_ctrl_bank.sv
// Per-channel synchronise/debounce with press, release, toggle and long-press
// outputs, plus a wrap-around up/down selector driven by two channels.
module btn_ctrl_bank #(
  parameter int NCH         = 4,
  parameter int DEB_CYCLES  = 1048576,
  parameter int LONG_CYCLES = 50000000,
  parameter int SEL_W       = 2,
  parameter int SEL_MOD     = 4,
  parameter int UP_CH       = 2,
  parameter int DN_CH       = 3
) (
  input  logic             ILA_clk,
  input  logic             rstn,
  btn_ctrl_bank_if.slave   bus
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);

  localparam logic [DW-1:0]    DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0]    LONG_MAX = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]    LONG_PRE = LW'(LONG_CYCLES - 2);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(SEL_MOD - 1);

  logic [NCH-1:0]   s0_q, s0_d;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   level_q, level_d;
  logic [NCH-1:0]   press_q, press_d;
  logic [NCH-1:0]   rel_q, rel_d;
  logic [NCH-1:0]   toggle_q, toggle_d;
  logic [NCH-1:0]   long_q, long_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    dcnt_q [NCH];
  logic [DW-1:0]    dcnt_d [NCH];
  logic [LW-1:0]    lcnt_q [NCH];
  logic [LW-1:0]    lcnt_d [NCH];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    s0_d    = bus.btn;
    s1_d    = s0_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      dcnt_d[i] = '0;
      lcnt_d[i] = '0;

      // Debounce: a level change is accepted only after DEB_CYCLES stable samples.
      if (s1_q[i] != level_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) begin
          level_d[i] = s1_q[i];
          press_d[i] = s1_q[i];
          rel_d[i]   = ~s1_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end

      // Long press counter saturates, so the pulse fires once per hold.
      if (level_q[i]) begin
        if (lcnt_q[i] != LONG_MAX) begin
          lcnt_d[i] = lcnt_q[i] + 1'b1;
          long_d[i] = (lcnt_q[i] == LONG_PRE);
        end else begin
          lcnt_d[i] = lcnt_q[i];
        end
      end
    end
  end

  always_comb begin
    toggle_d = bus.clr_toggle ? '0 : (toggle_q ^ press_q);

    sel_d = sel_q;
    if (long_q[DN_CH]) begin
      sel_d = '0;
    end else if (press_q[UP_CH] && press_q[DN_CH]) begin
      sel_d = sel_q;
    end else if (press_q[UP_CH]) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end else if (press_q[DN_CH]) begin
      sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      s0_q     <= '0;
      s1_q     <= '0;
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      toggle_q <= '0;
      long_q   <= '0;
      sel_q    <= '0;
      // NOTE: the counter arrays are real flops, not RAM, and must be reset so
      // that a reset mid-count discards any pending progress.
      dcnt_q   <= '{default: '0};
      lcnt_q   <= '{default: '0};
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      toggle_q <= toggle_d;
      long_q   <= long_d;
      sel_q    <= sel_d;
      dcnt_q   <= dcnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign bus.level      = level_q;
  assign bus.press      = press_q;
  assign bus.rel        = rel_q;
  assign bus.toggle     = toggle_q;
  assign bus.long_press = long_q;
  assign bus.sel        = sel_q;

endmodule

// File: tb/tb_btn_ctrl_bank.sv
// Directed bench for btn_ctrl_bank with short debounce/long-press constants;
// inputs change 1 time unit after a rising edge and outputs are sampled there too.
module tb_btn_ctrl_bank;

  localparam int NCH = 4;

  logic clk;
  logic rstn;

  int vec_cnt;
  int err_cnt;
  int press_cnt [NCH];
  int rel_cnt   [NCH];
  int long_cnt  [NCH];
  int overlap_cnt;

  btn_ctrl_bank_if #(.NCH(NCH), .SEL_W(2)) bus ();

  btn_ctrl_bank #(
    .NCH(NCH), .DEB_CYCLES(8), .LONG_CYCLES(32),
    .SEL_W(2), .SEL_MOD(3), .UP_CH(2), .DN_CH(3)
  ) dut (
    .ILA_clk (clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      long_cnt[i]  = 0;
    end
    overlap_cnt = 0;
  end

  // Pulse tallies, sampled on the falling edge so each 1-cycle pulse counts once.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus.press[i] === 1'b1)      press_cnt[i] = press_cnt[i] + 1;
      if (bus.rel[i] === 1'b1)        rel_cnt[i]   = rel_cnt[i] + 1;
      if (bus.long_press[i] === 1'b1) long_cnt[i]  = long_cnt[i] + 1;
    end
    if ((bus.press & bus.rel) !== 4'b0000) overlap_cnt = overlap_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_press(input logic [NCH-1:0] m);
    bus.btn = bus.btn | m;
    step(12);
    bus.btn = bus.btn & ~m;
    step(12);
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    bus.btn = '0;
    bus.clr_toggle = 1'b0;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if ({bus.level, bus.press, bus.rel, bus.toggle, bus.long_press} !== 20'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {bus.level, bus.press, bus.rel, bus.toggle, bus.long_press});
    end
    vec_cnt++;
    if (bus.sel !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_sel: got %0d, expected 0", bus.sel);
    end
    rstn = 1'b1;
    step(3);
  endtask

  task automatic test_clean_press;
    int p0, r0, l0;
    p0 = press_cnt[0]; r0 = rel_cnt[0]; l0 = long_cnt[0];
    bus.btn[0] = 1'b1;
    step(9);
    vec_cnt++;
    if (bus.level !== 4'b0000) begin
      err_cnt++; $display("FAIL clean_level_early: got %b, expected 0000", bus.level);
    end
    step(1);
    vec_cnt++;
    if (bus.level !== 4'b0001) begin
      err_cnt++; $display("FAIL clean_level_rise: got %b, expected 0001", bus.level);
    end
    vec_cnt++;
    if (bus.press !== 4'b0001) begin
      err_cnt++; $display("FAIL clean_press: got %b, expected 0001", bus.press);
    end
    step(1);
    vec_cnt++;
    if (bus.press !== 4'b0000) begin
      err_cnt++; $display("FAIL clean_press_width: got %b, expected 0000", bus.press);
    end
    vec_cnt++;
    if (bus.toggle !== 4'b0001) begin
      err_cnt++; $display("FAIL clean_toggle: got %b, expected 0001", bus.toggle);
    end
    step(9);
    bus.btn[0] = 1'b0;
    step(9);
    vec_cnt++;
    if (bus.level !== 4'b0001) begin
      err_cnt++; $display("FAIL clean_level_hold: got %b, expected 0001", bus.level);
    end
    step(1);
    vec_cnt++;
    if (bus.level !== 4'b0000 || bus.rel !== 4'b0001) begin
      err_cnt++;
      $display("FAIL clean_release: got level %b rel %b, expected level 0000 rel 0001",
               bus.level, bus.rel);
    end
    step(1);
    vec_cnt++;
    if (bus.rel !== 4'b0000) begin
      err_cnt++; $display("FAIL clean_release_width: got %b, expected 0000", bus.rel);
    end
    vec_cnt++;
    if (press_cnt[0] - p0 != 1 || rel_cnt[0] - r0 != 1 || long_cnt[0] - l0 != 0) begin
      err_cnt++;
      $display("FAIL clean_pulse_counts: got press %0d rel %0d long %0d, expected 1 1 0",
               press_cnt[0] - p0, rel_cnt[0] - r0, long_cnt[0] - l0);
    end
  endtask

  task automatic test_bounce;
    int p1;
    p1 = press_cnt[1];
    bus.btn[1] = 1'b1; step(5);
    bus.btn[1] = 1'b0; step(2);
    bus.btn[1] = 1'b1; step(5);
    bus.btn[1] = 1'b0; step(12);
    vec_cnt++;
    if (bus.level !== 4'b0000 || press_cnt[1] != p1) begin
      err_cnt++;
      $display("FAIL bounce_reject: got level %b presses %0d, expected level 0000 presses 0",
               bus.level, press_cnt[1] - p1);
    end
    bus.btn[1] = 1'b1; step(8);
    bus.btn[1] = 1'b0; step(2);
    vec_cnt++;
    if (bus.level !== 4'b0010 || bus.press !== 4'b0010) begin
      err_cnt++;
      $display("FAIL bounce_accept: got level %b press %b, expected 0010 0010",
               bus.level, bus.press);
    end
    step(1);
    vec_cnt++;
    if (bus.toggle !== 4'b0011) begin
      err_cnt++; $display("FAIL bounce_toggle: got %b, expected 0011", bus.toggle);
    end
    step(7);
    vec_cnt++;
    if (bus.level !== 4'b0000 || bus.rel !== 4'b0010) begin
      err_cnt++;
      $display("FAIL bounce_release: got level %b rel %b, expected 0000 0010",
               bus.level, bus.rel);
    end
    step(4);
  endtask

  task automatic test_selector;
    logic [1:0] exp_sel [3];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;
    bus.btn[2] = 1'b1;
    step(10);
    vec_cnt++;
    if (bus.press !== 4'b0100 || bus.sel !== 2'd0) begin
      err_cnt++;
      $display("FAIL sel_up_latency: got press %b sel %0d, expected 0100 0",
               bus.press, bus.sel);
    end
    step(1);
    vec_cnt++;
    if (bus.sel !== exp_sel[0]) begin
      err_cnt++; $display("FAIL sel_up_0: got %0d, expected %0d", bus.sel, exp_sel[0]);
    end
    step(1);
    bus.btn[2] = 1'b0;
    step(12);
    for (int k = 1; k < 3; k++) begin
      do_press(4'b0100);
      vec_cnt++;
      if (bus.sel !== exp_sel[k]) begin
        err_cnt++; $display("FAIL sel_up_%0d: got %0d, expected %0d", k, bus.sel, exp_sel[k]);
      end
    end
    do_press(4'b1000);
    vec_cnt++;
    if (bus.sel !== 2'd2) begin
      err_cnt++; $display("FAIL sel_down_wrap: got %0d, expected 2", bus.sel);
    end
    vec_cnt++;
    if (bus.toggle !== 4'b1111) begin
      err_cnt++; $display("FAIL sel_toggles: got %b, expected 1111", bus.toggle);
    end
  endtask

  task automatic test_simultaneous;
    bus.btn = bus.btn | 4'b1100;
    step(10);
    vec_cnt++;
    if (bus.press !== 4'b1100) begin
      err_cnt++; $display("FAIL simul_press: got %b, expected 1100", bus.press);
    end
    step(1);
    vec_cnt++;
    if (bus.sel !== 2'd2) begin
      err_cnt++; $display("FAIL simul_sel_hold: got %0d, expected 2", bus.sel);
    end
    vec_cnt++;
    if (bus.toggle !== 4'b0011) begin
      err_cnt++; $display("FAIL simul_toggle: got %b, expected 0011", bus.toggle);
    end
    bus.btn = bus.btn & 4'b0011;
    step(12);
  endtask

  task automatic test_long_press;
    int l3, p3;
    l3 = long_cnt[3]; p3 = press_cnt[3];
    bus.btn[3] = 1'b1;
    step(10);
    vec_cnt++;
    if (bus.press !== 4'b1000) begin
      err_cnt++; $display("FAIL long_press_edge: got %b, expected 1000", bus.press);
    end
    step(1);
    vec_cnt++;
    if (bus.sel !== 2'd1) begin
      err_cnt++; $display("FAIL long_sel_dec: got %0d, expected 1", bus.sel);
    end
    step(29);
    vec_cnt++;
    if (bus.long_press !== 4'b0000) begin
      err_cnt++; $display("FAIL long_early: got %b, expected 0000", bus.long_press);
    end
    step(1);
    vec_cnt++;
    if (bus.long_press !== 4'b1000 || bus.sel !== 2'd1) begin
      err_cnt++;
      $display("FAIL long_pulse: got long %b sel %0d, expected 1000 1", bus.long_press, bus.sel);
    end
    step(1);
    vec_cnt++;
    if (bus.long_press !== 4'b0000 || bus.sel !== 2'd0) begin
      err_cnt++;
      $display("FAIL long_clear_sel: got long %b sel %0d, expected 0000 0", bus.long_press, bus.sel);
    end
    step(18);
    bus.btn[3] = 1'b0;
    step(12);
    vec_cnt++;
    if (long_cnt[3] - l3 != 1 || press_cnt[3] - p3 != 1) begin
      err_cnt++;
      $display("FAIL long_no_repeat: got long %0d press %0d, expected 1 1",
               long_cnt[3] - l3, press_cnt[3] - p3);
    end
  endtask

  task automatic test_clr_toggle;
    bus.btn[2] = 1'b1;
    step(10);
    bus.clr_toggle = 1'b1;
    step(1);
    vec_cnt++;
    if (bus.toggle !== 4'b0000) begin
      err_cnt++; $display("FAIL clr_priority: got %b, expected 0000", bus.toggle);
    end
    vec_cnt++;
    if (bus.sel !== 2'd1) begin
      err_cnt++; $display("FAIL clr_sel_up: got %0d, expected 1", bus.sel);
    end
    bus.clr_toggle = 1'b0;
    step(1);
    bus.btn[2] = 1'b0;
    step(12);
    do_press(4'b0101);
    vec_cnt++;
    if (bus.toggle !== 4'b0101 || bus.sel !== 2'd2) begin
      err_cnt++;
      $display("FAIL clr_repress: got toggle %b sel %0d, expected 0101 2", bus.toggle, bus.sel);
    end
  endtask

  task automatic test_reset_midcount;
    bus.btn[0] = 1'b1;
    step(7);
    rstn = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.level, bus.press, bus.rel, bus.toggle, bus.long_press} !== 20'h0 ||
        bus.sel !== 2'd0) begin
      err_cnt++;
      $display("FAIL midreset_outputs: got %b sel %0d, expected all zero",
               {bus.level, bus.press, bus.rel, bus.toggle, bus.long_press}, bus.sel);
    end
    step(2);
    rstn = 1'b1;
    step(9);
    vec_cnt++;
    if (bus.press !== 4'b0000 || bus.level !== 4'b0000) begin
      err_cnt++;
      $display("FAIL midreset_early: got press %b level %b, expected 0000 0000",
               bus.press, bus.level);
    end
    step(1);
    vec_cnt++;
    if (bus.press !== 4'b0001 || bus.level !== 4'b0001) begin
      err_cnt++;
      $display("FAIL midreset_fresh_press: got press %b level %b, expected 0001 0001",
               bus.press, bus.level);
    end
    step(1);
    vec_cnt++;
    if (bus.toggle !== 4'b0001) begin
      err_cnt++; $display("FAIL midreset_toggle: got %b, expected 0001", bus.toggle);
    end
    bus.btn[0] = 1'b0;
    step(12);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_selector();
    test_simultaneous();
    test_long_press();
    test_clr_toggle();
    test_reset_midcount();
    vec_cnt++;
    if (overlap_cnt != 0) begin
      err_cnt++;
      $display("FAIL press_release_overlap: got %0d cycles, expected 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
